// File: rtl/ddr_arb_pkg.sv
// Shared types and defaults for the DDR frame arbiter.
// Holds FSM encoding, requester IDs and burst/frame defaults.
package ddr_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_WDATA,
      ST_RWAIT
   } arb_state_e;

   typedef logic [1:0] req_id_t;

   localparam req_id_t REQ_CAM0 = 2'd0;
   localparam req_id_t REQ_CAM1 = 2'd1;
   localparam req_id_t REQ_DISP = 2'd2;

   localparam int DEF_BURST_LEN   = 64;
   localparam int DEF_FRAME_WORDS = 460800;

endpackage

// File: rtl/ddr_frame_arbiter_addr_gen.sv
// Per-requester frame offset: advances one burst per completed
// burst, wraps at the frame end and clears on frame start.
// Ports: clk, rst_n, frame_start (pulse), held (requester owns the
//        current/just-issued grant), done (its burst completed),
//        offset (current word offset within the frame).
module frame_addr_gen
#(
   parameter int ADDR_W      = 28,
   parameter int BURST_LEN   = 64,
   parameter int FRAME_WORDS = 460800
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic              held,
   input  logic              done,
   output logic [ADDR_W-1:0] offset
);

   localparam logic [ADDR_W:0] STEP  = (ADDR_W+1)'(BURST_LEN);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(FRAME_WORDS);

   logic [ADDR_W-1:0] offset_q, offset_d;
   logic              pend_q, pend_d;
   logic [ADDR_W:0]   nxt;

   always_comb begin
      offset_d = offset_q;
      pend_d   = pend_q;
      nxt      = {1'b0, offset_q} + STEP;
      if (done) begin
         // A frame start seen while this requester held the grant
         // replaces the normal advance.
         if (pend_q || frame_start || nxt >= LIMIT) begin
            offset_d = '0;
         end else begin
            offset_d = nxt[ADDR_W-1:0];
         end
         pend_d = 1'b0;
      end else if (frame_start) begin
         if (held) begin
            pend_d = 1'b1;
         end else begin
            offset_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         offset_q <= '0;
         pend_q   <= 1'b0;
      end else begin
         offset_q <= offset_d;
         pend_q   <= pend_d;
      end
   end

   assign offset = offset_q;

endmodule

// File: rtl/ddr_frame_arbiter.sv
// Arbitrates one DDR user port between two camera write FIFOs and
// the display read FIFO, one burst outstanding at a time.
// Ports: camN_* camera FIFO side, disp_* display FIFO side,
//        cmd_*/wr_*/rd_* DDR user port, busy = FSM not idle.
module ddr_frame_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 28,
   parameter int                BURST_LEN   = DEF_BURST_LEN,
   parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
   parameter logic [ADDR_W-1:0] CAM0_BASE   = ADDR_W'('h0000000),
   parameter logic [ADDR_W-1:0] CAM1_BASE   = ADDR_W'('h0080000),
   parameter int                LVL_W       = 10,
   parameter int                DISP_DEPTH  = 1024,
   parameter int                RD_LOW_TH   = 256
)
(
   input  logic              ddr_clk,
   input  logic              ddr_rst_n,
   input  logic              ddr_init_done,
   input  logic              cam0_frame_start,
   input  logic [LVL_W-1:0]  cam0_rd_cnt,
   input  logic [DATA_W-1:0] cam0_data,
   output logic              cam0_rden,
   input  logic              cam1_frame_start,
   input  logic [LVL_W-1:0]  cam1_rd_cnt,
   input  logic [DATA_W-1:0] cam1_data,
   output logic              cam1_rden,
   input  logic              disp_frame_start,
   input  logic              disp_sel,
   input  logic [LVL_W-1:0]  disp_wr_cnt,
   output logic              disp_wren,
   output logic [DATA_W-1:0] disp_data,
   output logic              cmd_en,
   input  logic              cmd_ready,
   output logic              cmd_wr,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic              wr_valid,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ready,
   input  logic              rd_valid,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy
);

   if (RD_LOW_TH > DISP_DEPTH - BURST_LEN) begin : g_bad_cfg
      $error("RD_LOW_TH leaves no room for a full burst");
   end

   localparam int               CNT_W     = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
   localparam logic [LVL_W-1:0] BL_LVL    = LVL_W'(BURST_LEN);
   localparam logic [LVL_W-1:0] TH_LVL    = LVL_W'(RD_LOW_TH);

   arb_state_e        state_q, state_d;
   req_id_t           grant_q, grant_d;
   logic              cmd_wr_q, cmd_wr_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic              disp_en_q, disp_en_d;
   logic              disp_sel_q, disp_sel_d;

   logic              req_rd, req_c0, req_c1;
   logic              win_rd, win_c0, win_c1;
   logic              grant_fire, burst_done;
   logic [ADDR_W-1:0] disp_base;
   logic [ADDR_W-1:0] offset [3];
   logic [2:0]        fs_vec, held_vec, done_vec;

   assign req_rd = disp_en_q && (disp_wr_cnt < TH_LVL);
   assign req_c0 = cam0_rd_cnt >= BL_LVL;
   assign req_c1 = cam1_rd_cnt >= BL_LVL;

   // Display refills win outright; rr_ptr breaks camera ties.
   assign win_rd = req_rd;
   assign win_c0 = !req_rd && req_c0 && (!req_c1 || !rr_ptr_q);
   assign win_c1 = !req_rd && req_c1 && (!req_c0 || rr_ptr_q);

   assign disp_base = disp_sel_q ? CAM1_BASE : CAM0_BASE;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      cmd_wr_d   = cmd_wr_q;
      cmd_addr_d = cmd_addr_q;
      beat_d     = beat_q;
      rr_ptr_d   = rr_ptr_q;
      grant_fire = 1'b0;
      burst_done = 1'b0;
      cmd_en     = 1'b0;
      wr_valid   = 1'b0;
      wr_data    = '0;
      cam0_rden  = 1'b0;
      cam1_rden  = 1'b0;
      disp_wren  = 1'b0;
      disp_data  = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (ddr_init_done) begin
               unique case (1'b1)
                  win_rd: begin
                     grant_d    = REQ_DISP;
                     cmd_wr_d   = 1'b0;
                     cmd_addr_d = disp_base + offset[REQ_DISP];
                  end
                  win_c0: begin
                     grant_d    = REQ_CAM0;
                     cmd_wr_d   = 1'b1;
                     cmd_addr_d = CAM0_BASE + offset[REQ_CAM0];
                  end
                  win_c1: begin
                     grant_d    = REQ_CAM1;
                     cmd_wr_d   = 1'b1;
                     cmd_addr_d = CAM1_BASE + offset[REQ_CAM1];
                  end
                  default: ;
               endcase
               grant_fire = win_rd || win_c0 || win_c1;
               if (grant_fire) begin
                  state_d = ST_CMD;
               end
            end
         end
         ST_CMD: begin
            cmd_en = 1'b1;
            if (cmd_ready) begin
               state_d = cmd_wr_q ? ST_WDATA : ST_RWAIT;
               beat_d  = '0;
            end
         end
         ST_WDATA: begin
            wr_valid = 1'b1;
            wr_data  = (grant_q == REQ_CAM1) ? cam1_data : cam0_data;
            if (wr_ready) begin
               cam0_rden = (grant_q == REQ_CAM0);
               cam1_rden = (grant_q == REQ_CAM1);
               beat_d    = beat_q + CNT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  burst_done = 1'b1;
                  state_d    = ST_IDLE;
                  rr_ptr_d   = (grant_q == REQ_CAM0);
               end
            end
         end
         ST_RWAIT: begin
            disp_wren = rd_valid;
            disp_data = rd_data;
            if (rd_valid) begin
               beat_d = beat_q + CNT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  burst_done = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign disp_en_d  = disp_en_q | disp_frame_start;
   assign disp_sel_d = disp_frame_start ? disp_sel : disp_sel_q;

   always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
      if (!ddr_rst_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= REQ_CAM0;
         cmd_wr_q   <= 1'b0;
         cmd_addr_q <= '0;
         beat_q     <= '0;
         rr_ptr_q   <= 1'b0;
         disp_en_q  <= 1'b0;
         disp_sel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         cmd_wr_q   <= cmd_wr_d;
         cmd_addr_q <= cmd_addr_d;
         beat_q     <= beat_d;
         rr_ptr_q   <= rr_ptr_d;
         disp_en_q  <= disp_en_d;
         disp_sel_q <= disp_sel_d;
      end
   end

   assign fs_vec = {disp_frame_start, cam1_frame_start, cam0_frame_start};

   // A grant issued this cycle already used the old offset, so a
   // coincident frame start must be deferred like a mid-burst one.
   for (genvar g = 0; g < 3; g++) begin : g_addr
      assign held_vec[g] =
         (state_q != ST_IDLE && grant_q == req_id_t'(g)) ||
         (grant_fire && grant_d == req_id_t'(g));
      assign done_vec[g] = burst_done && grant_q == req_id_t'(g);

      frame_addr_gen #(
         .ADDR_W      (ADDR_W),
         .BURST_LEN   (BURST_LEN),
         .FRAME_WORDS (FRAME_WORDS)
      ) u_addr (
         .clk         (ddr_clk),
         .rst_n       (ddr_rst_n),
         .frame_start (fs_vec[g]),
         .held        (held_vec[g]),
         .done        (done_vec[g]),
         .offset      (offset[g])
      );
   end

   assign cmd_wr   = cmd_wr_q;
   assign cmd_addr = cmd_addr_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Directed bench for ddr_frame_arbiter; short frame so the
// wrap-around is reachable in a few bursts.
module tb_ddr_frame_arbiter;

   localparam int FW = 320;
   localparam logic [31:0] DA = 32'hA0A0_0001;
   localparam logic [31:0] DB = 32'hB1B1_0002;

   logic        ddr_clk;
   logic        ddr_rst_n;
   logic        ddr_init_done;
   logic        cam0_frame_start, cam1_frame_start;
   logic [9:0]  cam0_rd_cnt, cam1_rd_cnt;
   logic [31:0] cam0_data, cam1_data;
   logic        cam0_rden, cam1_rden;
   logic        disp_frame_start, disp_sel;
   logic [9:0]  disp_wr_cnt;
   logic        disp_wren;
   logic [31:0] disp_data;
   logic        cmd_en, cmd_ready, cmd_wr;
   logic [27:0] cmd_addr;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   ddr_frame_arbiter #(.FRAME_WORDS(FW)) dut (
      .ddr_clk          (ddr_clk),
      .ddr_rst_n        (ddr_rst_n),
      .ddr_init_done    (ddr_init_done),
      .cam0_frame_start (cam0_frame_start),
      .cam0_rd_cnt      (cam0_rd_cnt),
      .cam0_data        (cam0_data),
      .cam0_rden        (cam0_rden),
      .cam1_frame_start (cam1_frame_start),
      .cam1_rd_cnt      (cam1_rd_cnt),
      .cam1_data        (cam1_data),
      .cam1_rden        (cam1_rden),
      .disp_frame_start (disp_frame_start),
      .disp_sel         (disp_sel),
      .disp_wr_cnt      (disp_wr_cnt),
      .disp_wren        (disp_wren),
      .disp_data        (disp_data),
      .cmd_en           (cmd_en),
      .cmd_ready        (cmd_ready),
      .cmd_wr           (cmd_wr),
      .cmd_addr         (cmd_addr),
      .wr_valid         (wr_valid),
      .wr_data          (wr_data),
      .wr_ready         (wr_ready),
      .rd_valid         (rd_valid),
      .rd_data          (rd_data),
      .busy             (busy)
   );

   initial ddr_clk = 1'b0;
   always #5 ddr_clk = ~ddr_clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cmd(input string tag);
      int n;
      n = 0;
      while (!cmd_en && n < 200) begin
         @(negedge ddr_clk);
         #1;
         n++;
      end
      chk({tag, "_cmd_seen"}, cmd_en, 1);
   endtask

   task automatic accept_cmd();
      cmd_ready = 1'b1;
      @(posedge ddr_clk);
      #1;
      cmd_ready = 1'b0;
   endtask

   task automatic run_write(input bit toggle, input int fs_at,
                            output int r0, output int r1,
                            output int vc, output logic [31:0] wd);
      bit ph;
      ph = 1'b1;
      r0 = 0; r1 = 0; vc = 0; wd = '0;
      for (int i = 0; i < 300; i++) begin
         @(negedge ddr_clk);
         wr_ready = toggle ? ph : 1'b1;
         ph = ~ph;
         cam0_frame_start = (i == fs_at);
         cam1_frame_start = (i == fs_at);
         #1;
         if (!wr_valid) break;
         if (vc == 0) wd = wr_data;
         vc++;
         r0 += int'(cam0_rden);
         r1 += int'(cam1_rden);
      end
      wr_ready = 1'b0;
      cam0_frame_start = 1'b0;
      cam1_frame_start = 1'b0;
   endtask

   task automatic wr_burst(input string tag, input logic [27:0] addr,
                           input bit cam1, input bit toggle,
                           input int fs_at);
      int r0, r1, vc;
      logic [31:0] wd;
      wait_cmd(tag);
      chk({tag, "_wr"}, cmd_wr, 1);
      chk({tag, "_addr"}, cmd_addr, addr);
      accept_cmd();
      run_write(toggle, fs_at, r0, r1, vc, wd);
      chk({tag, "_rden"}, cam1 ? r1 : r0, 64);
      chk({tag, "_rden_other"}, cam1 ? r0 : r1, 0);
      chk({tag, "_vcyc"}, vc, toggle ? 127 : 64);
      chk({tag, "_wdata"}, wd, cam1 ? DB : DA);
      chk({tag, "_idle_gap"}, busy, 0);
   endtask

   initial begin
      int cnt, bad;
      ddr_rst_n = 1'b0;
      ddr_init_done = 1'b0;
      cam0_frame_start = 1'b0;
      cam1_frame_start = 1'b0;
      cam0_rd_cnt = 10'd100;
      cam1_rd_cnt = 10'd0;
      cam0_data = DA;
      cam1_data = DB;
      disp_frame_start = 1'b0;
      disp_sel = 1'b0;
      disp_wr_cnt = 10'd600;
      cmd_ready = 1'b0;
      wr_ready = 1'b0;
      rd_valid = 1'b0;
      rd_data = '0;

      repeat (2) @(negedge ddr_clk);
      #1;
      chk("rst_cmd_en", cmd_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_outs", {cmd_wr, wr_valid, cam0_rden, cam1_rden,
                       disp_wren}, 0);
      chk("rst_addr", cmd_addr, 0);
      chk("rst_data", {wr_data, disp_data}, 0);

      @(negedge ddr_clk);
      ddr_rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge ddr_clk);
         #1;
         cnt += int'(cmd_en | busy);
      end
      chk("no_grant_wo_init", cnt, 0);

      @(negedge ddr_clk);
      ddr_init_done = 1'b1;
      #1;
      chk("init_pre_edge", cmd_en, 0);
      @(negedge ddr_clk);
      #1;
      chk("init_cmd_en", cmd_en, 1);
      chk("init_busy", busy, 1);
      @(negedge ddr_clk);
      #1;
      chk("cmd_hold_en", cmd_en, 1);
      chk("cmd_hold_addr", cmd_addr, 0);
      cam0_rd_cnt = 10'd200;
      cam1_rd_cnt = 10'd200;
      wr_burst("b0_cam0", 28'h0, 1'b0, 1'b0, -1);

      wr_burst("b1_cam1", 28'h0080000, 1'b1, 1'b0, -1);
      wr_burst("b2_cam0", 28'h0000040, 1'b0, 1'b0, -1);
      wr_burst("b3_cam1", 28'h0080040, 1'b1, 1'b0, -1);

      wait_cmd("b4");
      @(negedge ddr_clk);
      disp_sel = 1'b1;
      disp_wr_cnt = 10'd100;
      disp_frame_start = 1'b1;
      @(negedge ddr_clk);
      disp_frame_start = 1'b0;
      disp_sel = 1'b0;
      #1;
      wr_burst("b4_cam0", 28'h0000080, 1'b0, 1'b0, -1);

      wait_cmd("rd");
      chk("rd_wr", cmd_wr, 0);
      chk("rd_addr", cmd_addr, 28'h0080000);
      rd_valid = 1'b1;
      #1;
      chk("rd_ignored_in_cmd", disp_wren, 0);
      rd_valid = 1'b0;
      accept_cmd();
      disp_wr_cnt = 10'd600;
      cnt = 0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge ddr_clk);
         rd_valid = (i % 4 != 3);
         rd_data = 32'hD000_0000 + i;
         #1;
         cnt += int'(disp_wren);
         if (disp_wren && disp_data !== rd_data) bad++;
      end
      rd_valid = 1'b0;
      chk("rd_wren_count", cnt, 64);
      chk("rd_data_pass", bad, 0);

      wr_burst("b5_cam1_tgl", 28'h0080080, 1'b1, 1'b1, -1);
      cam1_rd_cnt = 10'd0;
      wr_burst("wrap_a", 28'h00000C0, 1'b0, 1'b0, -1);
      wr_burst("wrap_b", 28'h0000100, 1'b0, 1'b0, -1);
      wr_burst("wrap_c", 28'h0000000, 1'b0, 1'b0, -1);

      wr_burst("fs_mid", 28'h0000040, 1'b0, 1'b0, 10);
      cam1_rd_cnt = 10'd200;
      wr_burst("fs_cam1", 28'h0080000, 1'b1, 1'b0, -1);

      wait_cmd("fs_cam0");
      chk("fs_cam0_addr", cmd_addr, 28'h0);
      ddr_init_done = 1'b0;
      wr_burst("init_drop", 28'h0, 1'b0, 1'b0, -1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge ddr_clk);
         #1;
         cnt += int'(cmd_en | busy);
      end
      chk("no_grant_after_drop", cnt, 0);

      ddr_init_done = 1'b1;
      wait_cmd("rst_mid");
      chk("rst_mid_addr", cmd_addr, 28'h0080040);
      accept_cmd();
      @(negedge ddr_clk);
      wr_ready = 1'b1;
      #1;
      chk("rst_mid_active", wr_valid, 1);
      ddr_rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_outs", {wr_valid, cam1_rden, cmd_en}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
